// File: rtl/acc_diff.sv
// acc_diff: comb-style differentiator for a 22-bit running-sum stream.
// Subtracts the sample M accepted samples back, then saturates to 20 bits.
// Two register stages: the difference is registered on the accepting edge,
// and the saturated result is registered on the following edge.
module acc_diff #(
    parameter int M     = 1,
    parameter int PRIME = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [21:0] din,
    input  logic               din_valid,
    input  logic               clr,
    output logic signed [19:0] dout,
    output logic               dout_valid,
    output logic               ovf
);

    typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;

    state_t             state;
    logic [2:0]         fill_cnt;
    logic [2:0]         next_cnt;
    logic signed [21:0] hist [0:M-1];
    logic signed [21:0] tap;
    logic signed [21:0] diff;
    logic               emit;
    logic signed [21:0] s1_diff;
    logic               s1_valid;
    logic signed [19:0] sat_val;
    logic               sat_ovf;

    // Difference against the oldest held sample (zero when history is being cleared),
    // strobe qualification, and saturation of the stage-1 result.
    always_comb begin
        next_cnt = fill_cnt + 3'd1;
        tap      = clr ? 22'sd0 : hist[M-1];
        diff     = din - tap;
        emit     = (PRIME == 0) || (!clr && state == RUN);
        sat_val  = s1_diff[19:0];
        sat_ovf  = 1'b0;
        if (s1_diff > 22'sd524287) begin
            sat_val = 20'sh7FFFF;
            sat_ovf = 1'b1;
        end else if (s1_diff < -22'sd524288) begin
            sat_val = 20'sh80000;
            sat_ovf = 1'b1;
        end
    end

    // History shift register: advances only on accepted samples; clear zeroes it
    // and, if a sample arrives on the same edge, that sample becomes the newest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++) hist[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < M; i++) hist[i] <= '0;
            if (din_valid) hist[0] <= din;
        end else if (din_valid) begin
            hist[0] <= din;
            for (int i = 1; i < M; i++) hist[i] <= hist[i-1];
        end
    end

    // Fill-state tracker: counts accepted samples until M are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            fill_cnt <= '0;
        end else if (din_valid) begin
            if (clr || state == EMPTY) begin
                fill_cnt <= 3'd1;
                state    <= (M == 1) ? RUN : FILL;
            end else if (state == FILL) begin
                fill_cnt <= next_cnt;
                if (next_cnt == 3'(M)) state <= RUN;
            end
        end else if (clr) begin
            state    <= EMPTY;
            fill_cnt <= '0;
        end
    end

    // Stage 1: register the raw 22-bit difference of each accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
        end else begin
            s1_valid <= din_valid && emit;
            if (din_valid) s1_diff <= diff;
        end
    end

    // Stage 2: present the saturated result; a clear drops the stage-1 result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout       <= '0;
            ovf        <= 1'b0;
        end else begin
            dout_valid <= s1_valid && !clr;
            if (s1_valid && !clr) begin
                dout <= sat_val;
                ovf  <= sat_ovf;
            end
        end
    end

endmodule
